// File: rtl/pcap_capture_uengine.sv
// Capture engine: admits whole packets into a word buffer and re-emits each one behind a 256-bit capture header.
// Optional macro CAPTURE_SNAPLEN_EN adds snaplen_words, which caps the number of stored words per packet.
module pcap_capture_uengine #(
    parameter int C_M_AXIS_DATA_WIDTH  = 256,
    parameter int C_S_AXIS_DATA_WIDTH  = 256,
    parameter int C_M_AXIS_TUSER_WIDTH = 128,
    parameter int C_S_AXIS_TUSER_WIDTH = 128,
    parameter int DATA_DEPTH_BITS      = 9,
    parameter int META_DEPTH_BITS      = 5
) (
    input  logic                              axi_aclk,
    input  logic                              sw_rst,
    input  logic                              capture_en,
    input  logic [63:0]                       timestamp,
`ifdef CAPTURE_SNAPLEN_EN
    input  logic [7:0]                        snaplen_words,
`endif
    input  logic [C_S_AXIS_DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  s_axis_tstrb,
    input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   s_axis_tuser,
    input  logic                              s_axis_tvalid,
    input  logic                              s_axis_tlast,
    output logic                              s_axis_tready,
    output logic [C_M_AXIS_DATA_WIDTH-1:0]    m_axis_tdata,
    output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  m_axis_tstrb,
    output logic [C_M_AXIS_TUSER_WIDTH-1:0]   m_axis_tuser,
    output logic                              m_axis_tvalid,
    output logic                              m_axis_tlast,
    input  logic                              m_axis_tready,
    output logic [31:0]                       stat_pkt_count,
    output logic [31:0]                       stat_drop_count
);
    localparam int DEPTH  = 1 << DATA_DEPTH_BITS;
    localparam int MDEPTH = 1 << META_DEPTH_BITS;
    localparam int FW     = DATA_DEPTH_BITS + 1;
    localparam int MCW    = META_DEPTH_BITS + 1;
    localparam int NW     = 12;
    localparam int SW     = C_M_AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {I_IDLE, I_ACCEPT, I_DROP} istate_t;
    typedef enum logic [1:0] {E_IDLE, E_HDR, E_DATA} estate_t;
    typedef struct packed {
        logic [63:0]   ts;
        logic [15:0]   bytes;
        logic [15:0]   ports;
        logic          trunc;
        logic [31:0]   drops;
        logic [NW-1:0] words;
    } hdr_t;

    function automatic hdr_t mk_hdr(input logic [63:0] ts, input logic [15:0] len, input logic [15:0] ports,
                                    input logic trunc, input logic [31:0] drops, input logic [NW-1:0] words);
        hdr_t h;
        h.ts    = ts;
        h.bytes = trunc ? {words[10:0], 5'd0} : len;
        h.ports = ports;
        h.trunc = trunc;
        h.drops = drops;
        h.words = words;
        return h;
    endfunction

    function automatic logic [SW-1:0] last_strb(input logic [15:0] bytes);
        if (bytes[4:0] == 5'd0) return '1;
        return (SW'(1) << bytes[4:0]) - SW'(1);
    endfunction

    logic [C_S_AXIS_DATA_WIDTH-1:0] data_mem [DEPTH];
    hdr_t                           hdr_mem  [MDEPTH];

    istate_t ist_q, ist_d;
    estate_t est_q, est_d;
    logic                       tready_q, in_pkt_q, in_pkt_d;
    logic [FW-1:0]              free_q, free_d;
    logic [DATA_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [META_DEPTH_BITS-1:0] hwr_q, hwr_d, hrd_q, hrd_d;
    logic [MCW-1:0]             hcnt_q, hcnt_d;
    logic [31:0]                drop_cnt_q, drop_cnt_d, pkt_cnt_q, pkt_cnt_d;
    logic [NW-1:0]              written_q, written_d, need_q, need_d, left_q, left_d;
    logic                       trunc_q, trunc_d;
    logic [63:0]                ts_q, ts_d;
    logic [15:0]                len_q, len_d, ports_q, ports_d, cur_bytes_q, cur_bytes_d;
    logic [C_M_AXIS_DATA_WIDTH-1:0]  mdata_q, mdata_d;
    logic [SW-1:0]                   mstrb_q, mstrb_d;
    logic [C_M_AXIS_TUSER_WIDTH-1:0] muser_q, muser_d;
    logic                            mvalid_q, mvalid_d, mlast_q, mlast_d;

    logic          beat, admit, mem_we, hdr_push, hdr_pop, hdr_avail, release_out, wr_ok, t_final;
    logic          load_hdr, load_word;
    logic [15:0]   len_in;
    logic [NW-1:0] need_full, need_new, reserve, release_in, w_final;
    hdr_t          hdr_in, hdr_out;
    logic          unused_in;

    assign unused_in = ^{s_axis_tstrb, s_axis_tuser[C_S_AXIS_TUSER_WIDTH-1:32]};
    assign beat      = s_axis_tvalid && tready_q;
    assign len_in    = s_axis_tuser[15:0];
    assign need_full = NW'((17'(len_in) + 17'd31) >> 5);
`ifdef CAPTURE_SNAPLEN_EN
    assign need_new  = (snaplen_words != 8'd0 && need_full > NW'(snaplen_words)) ? NW'(snaplen_words) : need_full;
`else
    assign need_new  = need_full;
`endif
    assign admit     = capture_en && (len_in != 16'd0) && (32'(need_new) <= 32'(free_q)) && (hcnt_q != MCW'(MDEPTH));
    assign hdr_avail = (hcnt_q != '0);
    assign hdr_out   = hdr_mem[hrd_q];

    // Ingress: admission, reservation and header construction
    always_comb begin
        ist_d = ist_q; written_d = written_q; need_d = need_q; trunc_d = trunc_q;
        ts_d = ts_q; len_d = len_q; ports_d = ports_q; drop_cnt_d = drop_cnt_q; in_pkt_d = in_pkt_q;
        mem_we = 1'b0; reserve = '0; release_in = '0; hdr_push = 1'b0; hdr_in = '0;
        wr_ok   = written_q < need_q;
        w_final = written_q + NW'(wr_ok);
        t_final = trunc_q | !wr_ok;
        if (beat) begin
            in_pkt_d = !s_axis_tlast;
            case (ist_q)
                I_IDLE: begin
                    // A stale continuation after reset is discarded silently
                    if (in_pkt_q) begin
                        if (!s_axis_tlast) ist_d = I_DROP;
                    end else if (admit) begin
                        mem_we = 1'b1; reserve = need_new;
                        written_d = NW'(1); need_d = need_new; trunc_d = 1'b0;
                        ts_d = timestamp; len_d = len_in; ports_d = s_axis_tuser[31:16];
                        if (s_axis_tlast) begin
                            hdr_push   = 1'b1;
                            hdr_in     = mk_hdr(timestamp, len_in, s_axis_tuser[31:16], 1'b0, drop_cnt_q, NW'(1));
                            release_in = need_new - NW'(1);
                        end else begin
                            ist_d = I_ACCEPT;
                        end
                    end else begin
                        drop_cnt_d = drop_cnt_q + 32'd1;
                        if (!s_axis_tlast) ist_d = I_DROP;
                    end
                end
                I_ACCEPT: begin
                    mem_we = wr_ok; written_d = w_final; trunc_d = t_final;
                    if (s_axis_tlast) begin
                        hdr_push   = 1'b1;
                        hdr_in     = mk_hdr(ts_q, len_q, ports_q, t_final, drop_cnt_q, w_final);
                        release_in = need_q - w_final;
                        ist_d      = I_IDLE;
                    end
                end
                I_DROP:  if (s_axis_tlast) ist_d = I_IDLE;
                default: ist_d = I_IDLE;
            endcase
        end
    end

    // Egress: header word followed by the stored data words
    always_comb begin
        est_d = est_q; mvalid_d = mvalid_q; mlast_d = mlast_q; mdata_d = mdata_q; mstrb_d = mstrb_q;
        muser_d = muser_q; rd_ptr_d = rd_ptr_q; left_d = left_q; cur_bytes_d = cur_bytes_q; pkt_cnt_d = pkt_cnt_q;
        hdr_pop = 1'b0; release_out = 1'b0; load_hdr = 1'b0; load_word = 1'b0;
        case (est_q)
            E_IDLE: load_hdr = hdr_avail;
            E_HDR:  load_word = m_axis_tready;
            E_DATA: if (m_axis_tready) begin
                release_out = 1'b1;
                if (mlast_q) begin
                    pkt_cnt_d = pkt_cnt_q + 32'd1;
                    load_hdr  = hdr_avail;
                    if (!hdr_avail) begin
                        mvalid_d = 1'b0; mlast_d = 1'b0; est_d = E_IDLE;
                    end
                end else begin
                    load_word = 1'b1;
                end
            end
            default: est_d = E_IDLE;
        endcase
        if (load_hdr) begin
            hdr_pop  = 1'b1;
            mvalid_d = 1'b1; mlast_d = 1'b0; mstrb_d = '1;
            mdata_d  = {96'd0, hdr_out.drops, 31'd0, hdr_out.trunc, hdr_out.ports, hdr_out.bytes, hdr_out.ts};
            muser_d  = {{(C_M_AXIS_TUSER_WIDTH-32){1'b0}}, hdr_out.ports, hdr_out.bytes};
            left_d   = hdr_out.words; cur_bytes_d = hdr_out.bytes;
            est_d    = E_HDR;
        end
        if (load_word) begin
            mdata_d  = data_mem[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + DATA_DEPTH_BITS'(1);
            left_d   = left_q - NW'(1);
            mlast_d  = (left_q == NW'(1));
            mstrb_d  = (left_q == NW'(1)) ? last_strb(cur_bytes_q) : '1;
            est_d    = E_DATA;
        end
    end

    assign wr_ptr_d = wr_ptr_q + DATA_DEPTH_BITS'(mem_we);
    assign hwr_d    = hwr_q + META_DEPTH_BITS'(hdr_push);
    assign hrd_d    = hrd_q + META_DEPTH_BITS'(hdr_pop);
    assign hcnt_d   = hcnt_q + MCW'(hdr_push) - MCW'(hdr_pop);
    assign free_d   = free_q + FW'(release_in) + FW'(release_out) - FW'(reserve);

    always_ff @(posedge axi_aclk) begin
        in_pkt_q <= in_pkt_d;
        if (sw_rst) begin
            ist_q <= I_IDLE; est_q <= E_IDLE; tready_q <= 1'b0;
            free_q <= FW'(DEPTH); wr_ptr_q <= '0; rd_ptr_q <= '0;
            hwr_q <= '0; hrd_q <= '0; hcnt_q <= '0;
            drop_cnt_q <= '0; pkt_cnt_q <= '0;
            mdata_q <= '0; mstrb_q <= '0; muser_q <= '0; mvalid_q <= 1'b0; mlast_q <= 1'b0;
        end else begin
            ist_q <= ist_d; est_q <= est_d; tready_q <= 1'b1;
            free_q <= free_d; wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d;
            hwr_q <= hwr_d; hrd_q <= hrd_d; hcnt_q <= hcnt_d;
            drop_cnt_q <= drop_cnt_d; pkt_cnt_q <= pkt_cnt_d;
            mdata_q <= mdata_d; mstrb_q <= mstrb_d; muser_q <= muser_d; mvalid_q <= mvalid_d; mlast_q <= mlast_d;
        end
    end

    always_ff @(posedge axi_aclk) begin
        written_q <= written_d; need_q <= need_d; trunc_q <= trunc_d; ts_q <= ts_d;
        len_q <= len_d; ports_q <= ports_d; left_q <= left_d; cur_bytes_q <= cur_bytes_d;
        if (mem_we)   data_mem[wr_ptr_q] <= s_axis_tdata;
        if (hdr_push) hdr_mem[hwr_q]     <= hdr_in;
    end

    assign s_axis_tready   = tready_q;
    assign m_axis_tdata    = mdata_q;
    assign m_axis_tstrb    = mstrb_q;
    assign m_axis_tuser    = muser_q;
    assign m_axis_tvalid   = mvalid_q;
    assign m_axis_tlast    = mlast_q;
    assign stat_pkt_count  = pkt_cnt_q;
    assign stat_drop_count = drop_cnt_q;
endmodule

// File: tb/tb_pcap_capture_uengine.sv
// Directed bench for pcap_capture_uengine built with a 16-word data buffer; egress beats are collected
// by a monitor and compared against hand-computed headers and data words.
module tb_pcap_capture_uengine;
    logic         clk = 1'b0;
    logic         sw_rst = 1'b1;
    logic         capture_en = 1'b1;
    logic [63:0]  timestamp = '0;
    logic [255:0] s_axis_tdata = '0;
    logic [31:0]  s_axis_tstrb = '1;
    logic [127:0] s_axis_tuser = '0;
    logic         s_axis_tvalid = 1'b0;
    logic         s_axis_tlast = 1'b0;
    logic         s_axis_tready;
    logic [255:0] m_axis_tdata;
    logic [31:0]  m_axis_tstrb;
    logic [127:0] m_axis_tuser;
    logic         m_axis_tvalid, m_axis_tlast;
    logic         m_axis_tready = 1'b0;
    logic [31:0]  stat_pkt_count, stat_drop_count;
`ifdef CAPTURE_SNAPLEN_EN
    logic [7:0]   snaplen_words = 8'd0;
`endif

    int errors = 0;
    int checks = 0;
    int rmode  = 0;

    logic [255:0] q_data[$];
    logic [31:0]  q_strb[$];
    logic [127:0] q_user[$];
    logic         q_last[$];

    always #5 clk = ~clk;

    pcap_capture_uengine #(.DATA_DEPTH_BITS(4)) dut (
        .axi_aclk(clk), .sw_rst(sw_rst), .capture_en(capture_en), .timestamp(timestamp),
`ifdef CAPTURE_SNAPLEN_EN
        .snaplen_words(snaplen_words),
`endif
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tuser(s_axis_tuser),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tlast(m_axis_tlast), .m_axis_tready(m_axis_tready),
        .stat_pkt_count(stat_pkt_count), .stat_drop_count(stat_drop_count)
    );

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] dw(input int p, input int b);
        logic [31:0] w;
        w = {p[15:0], b[15:0]};
        return {8{w}};
    endfunction

    function automatic logic [255:0] hdr(input logic [63:0] ts, input logic [15:0] bytes, input int p,
                                         input logic tr, input logic [31:0] drops);
        logic [255:0] h;
        h = '0;
        h[63:0] = ts; h[79:64] = bytes; h[87:80] = p[7:0]; h[95:88] = p[7:0] + 8'h10;
        h[96] = tr; h[159:128] = drops;
        return h;
    endfunction

    // egress response pattern: 0 = stall, 1 = always ready, other = toggle each cycle
    initial forever begin
        @(posedge clk); #1;
        case (rmode)
            0:       m_axis_tready = 1'b0;
            1:       m_axis_tready = 1'b1;
            default: m_axis_tready = ~m_axis_tready;
        endcase
    end

    initial begin : monitor
        logic         prev_stall;
        logic [255:0] pd;
        logic [31:0]  ps;
        logic [127:0] pu;
        logic         pl;
        prev_stall = 1'b0; pd = '0; ps = '0; pu = '0; pl = 1'b0;
        forever begin
            @(negedge clk);
            if (prev_stall) begin
                chk("hold_data", m_axis_tdata, pd);
                chk("hold_ctl", 256'({m_axis_tvalid, m_axis_tstrb, m_axis_tuser, m_axis_tlast}), 256'({1'b1, ps, pu, pl}));
            end
            if (m_axis_tvalid && m_axis_tready) begin
                q_data.push_back(m_axis_tdata); q_strb.push_back(m_axis_tstrb);
                q_user.push_back(m_axis_tuser); q_last.push_back(m_axis_tlast);
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            pd = m_axis_tdata; ps = m_axis_tstrb; pu = m_axis_tuser; pl = m_axis_tlast;
        end
    end

    task automatic send(input int p, input int len, input int nbeats, input logic [63:0] ts, input bit flip);
        for (int b = 0; b < nbeats; b++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = dw(p, b);
            s_axis_tuser  = {96'd0, p[7:0] + 8'h10, p[7:0], len[15:0]};
            s_axis_tlast  = (b == nbeats - 1);
            timestamp     = ts + 64'(b);
            @(posedge clk); #1;
            if (flip && b == 0) capture_en = ~capture_en;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    task automatic wait_caps(input int n);
        for (int i = 0; i < 400; i++) begin
            if (q_data.size() >= n) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("cap_count", 256'(q_data.size()), 256'(n));
    endtask

    task automatic chk_beat(input string tag, input int idx, input logic [255:0] data, input logic [31:0] strb, input logic last);
        chk({tag, "_data"}, q_data[idx], data);
        chk({tag, "_strb_last"}, 256'({q_strb[idx], q_last[idx]}), 256'({strb, last}));
    endtask

    task automatic chk_hdr(input string tag, input int idx, input int p, input logic [63:0] ts,
                           input logic [15:0] bytes, input logic tr, input logic [31:0] drops);
        chk_beat(tag, idx, hdr(ts, bytes, p, tr, drops), 32'hFFFF_FFFF, 1'b0);
        chk({tag, "_tuser"}, 256'(q_user[idx]), 256'({96'd0, p[7:0] + 8'h10, p[7:0], bytes}));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctl", 256'({s_axis_tready, m_axis_tvalid, m_axis_tlast, m_axis_tstrb, m_axis_tuser}), 256'(0));
        chk("rst_data", m_axis_tdata, '0);
        chk("rst_cnt", 256'({stat_pkt_count, stat_drop_count}), 256'(0));
        sw_rst = 1'b0;
        @(posedge clk); #1;
        chk("ready_after_rst", 256'(s_axis_tready), 256'(1));

        // 64B packet, two full words
        rmode = 1;
        send(1, 64, 2, 64'h1234, 1'b0);
        wait_caps(3);
        chk_hdr("a_hdr", 0, 1, 64'h1234, 16'd64, 1'b0, 32'd0);
        chk_beat("a_w0", 1, dw(1, 0), 32'hFFFF_FFFF, 1'b0);
        chk_beat("a_w1", 2, dw(1, 1), 32'hFFFF_FFFF, 1'b1);
        chk("a_pkt", 256'(stat_pkt_count), 256'(1));

        // 65B packet, one byte in the last word
        send(2, 65, 3, 64'h2000, 1'b0);
        wait_caps(7);
        chk_hdr("b_hdr", 3, 2, 64'h2000, 16'd65, 1'b0, 32'd0);
        chk_beat("b_w1", 5, dw(2, 1), 32'hFFFF_FFFF, 1'b0);
        chk_beat("b_w2", 6, dw(2, 2), 32'h0000_0001, 1'b1);
        chk("b_pkt", 256'(stat_pkt_count), 256'(2));

        // 1500B cannot fit 16 words: dropped, nothing emitted
        rmode = 0;
        send(3, 1500, 47, 64'h3000, 1'b0);
        chk("c_ready", 256'(s_axis_tready), 256'(1));
        repeat (10) @(posedge clk);
        #1;
        chk("c_drop", 256'(stat_drop_count), 256'(1));
        chk("c_none", 256'({q_data.size(), m_axis_tvalid}), 256'({32'd7, 1'b0}));

        // back-to-back packets under a toggling egress ready
        rmode = 2;
        send(4, 64, 2, 64'h4000, 1'b0);
        send(5, 64, 2, 64'h5000, 1'b0);
        wait_caps(13);
        chk_hdr("d_hdr0", 7, 4, 64'h4000, 16'd64, 1'b0, 32'd1);
        chk_beat("d_w01", 9, dw(4, 1), 32'hFFFF_FFFF, 1'b1);
        chk_hdr("d_hdr1", 10, 5, 64'h5000, 16'd64, 1'b0, 32'd1);
        chk_beat("d_w10", 11, dw(5, 0), 32'hFFFF_FFFF, 1'b0);
        chk_beat("d_w11", 12, dw(5, 1), 32'hFFFF_FFFF, 1'b1);
        chk("d_pkt", 256'(stat_pkt_count), 256'(4));

        // capture_en only matters at SOP
        rmode = 1;
        capture_en = 1'b0;
        send(6, 64, 2, 64'h6000, 1'b1);
        send(7, 64, 2, 64'h7000, 1'b1);
        capture_en = 1'b1;
        wait_caps(16);
        chk("e_drop", 256'(stat_drop_count), 256'(2));
        chk_hdr("e_hdr", 13, 7, 64'h7000, 16'd64, 1'b0, 32'd2);
        chk_beat("e_w1", 15, dw(7, 1), 32'hFFFF_FFFF, 1'b1);

        // zero-length single beat is dropped
        send(8, 0, 1, 64'h8000, 1'b0);
        repeat (5) @(posedge clk);
        #1;
        chk("f_drop", 256'(stat_drop_count), 256'(3));

        // extra beats beyond the claimed length are truncated
        send(9, 32, 3, 64'h9000, 1'b0);
        wait_caps(18);
        chk_hdr("g_hdr", 16, 9, 64'h9000, 16'd32, 1'b1, 32'd3);
        chk_beat("g_w0", 17, dw(9, 0), 32'hFFFF_FFFF, 1'b1);
        chk("g_pkt", 256'(stat_pkt_count), 256'(6));

        // buffer exactly full: next packet dropped, then space returns after drain
        rmode = 0;
        send(10, 512, 16, 64'hA000, 1'b0);
        send(11, 32, 1, 64'hB000, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        chk("h_full", 256'({stat_drop_count, stat_pkt_count, q_data.size()}), 256'({32'd4, 32'd6, 32'd18}));
        rmode = 1;
        wait_caps(35);
        chk_hdr("h_hdr", 18, 10, 64'hA000, 16'd512, 1'b0, 32'd3);
        chk_beat("h_w15", 34, dw(10, 15), 32'hFFFF_FFFF, 1'b1);
        send(12, 32, 1, 64'hC000, 1'b0);
        wait_caps(37);
        chk_hdr("h_after", 35, 12, 64'hC000, 16'd32, 1'b0, 32'd4);
        chk_beat("h_after_w0", 36, dw(12, 0), 32'hFFFF_FFFF, 1'b1);
        chk("h_pkt", 256'(stat_pkt_count), 256'(8));

`ifdef CAPTURE_SNAPLEN_EN
        snaplen_words = 8'd2;
        send(13, 256, 8, 64'hD000, 1'b0);
        wait_caps(40);
        chk_hdr("s_hdr", 37, 13, 64'hD000, 16'd64, 1'b1, 32'd4);
        chk_beat("s_w1", 39, dw(13, 1), 32'hFFFF_FFFF, 1'b1);
        chk("s_pkt", 256'(stat_pkt_count), 256'(9));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
